// File: rtl/vedic8x8_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vedic_pkg
//  Description : Shared types and constants for the sequential 8x8 Vedic
//                multiplier: FSM state encoding, step count, and the
//                per-step nibble-select and shift tables.
//  Revision    : 1.0 - initial release
// ============================================================================
package vedic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NSTEPS = 4;
  localparam int STEP_W = 2;

  // Left shift applied to the 4x4 partial product at each step.
  localparam logic [3:0] SHIFT_TBL [NSTEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

  // Bit s set => step s uses the high nibble of that operand.
  //   step 0: aL*bL, step 1: aH*bL, step 2: aL*bH, step 3: aH*bH
  localparam logic [NSTEPS-1:0] A_HI_SEL = 4'b1010;
  localparam logic [NSTEPS-1:0] B_HI_SEL = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/vedic8x8_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface   : vedic8x8_seq_if
//  Description : Operand and product handshakes of the sequential multiplier.
//  Signals     : in_valid/in_ready/a/b   operand channel (valid/ready)
//                out_valid/out_ready/product  result channel (valid/ready)
//  Modports    : master - operand producer / product consumer
//                slave  - the multiplier
//  Revision    : 1.0 - initial release
// ============================================================================
interface vedic8x8_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface
`default_nettype wire

// File: rtl/vedic8x8_seq_mul4x4.sv
`default_nettype none
// ============================================================================
//  Module      : vedic_mul4x4
//  Description : Combinational 4x4 -> 8 unsigned multiplier, Urdhva-
//                Tiryagbhyam (vertical and crosswise) form: each output
//                column sums its crosswise bit products, then the column
//                sums are resolved with a ripple of multi-bit carries.
//  Ports       : a_i [3:0]  multiplicand nibble
//                b_i [3:0]  multiplier nibble
//                p_o [7:0]  a_i * b_i
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic_mul4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [2:0] col [7];   // column k holds sum of a[i]&b[j] with i+j==k (max 4)
  logic [2:0] carry;     // carry into the next column (max 3)
  logic [3:0] t;
  logic [7:0] prod;

  always_comb begin
    for (int k = 0; k < 7; k++) begin
      col[k] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        col[i+j] = col[i+j] + {2'b00, a_i[i] & b_i[j]};
      end
    end

    prod  = '0;
    carry = '0;
    t     = '0;
    for (int k = 0; k < 7; k++) begin
      t       = {1'b0, col[k]} + {1'b0, carry};
      prod[k] = t[0];
      carry   = t[3:1];
    end
    // Residual carry after the top column is at most 1.
    prod[7] = carry[0];
    p_o     = prod;
  end

endmodule
`default_nettype wire

// File: rtl/vedic8x8_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vedic8x8_seq
//  Description : Multi-cycle 8x8 unsigned multiplier. One 4x4 Vedic core is
//                reused over four steps; nibble-shifted partial products are
//                accumulated into a 16-bit register. Zero operands may
//                bypass the computation (SKIP_ZERO).
//  Parameters  : SKIP_ZERO  1: a==0 or b==0 completes in one cycle
//  Ports       : clk    rising-edge clock
//                rst_n  synchronous active-low reset
//                bus    vedic8x8_seq_if.slave (operand + product handshakes)
//  Revision    : 1.0 - initial release
// ============================================================================
module vedic8x8_seq
  import vedic_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  vedic8x8_seq_if.slave  bus
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q,  step_d;
  logic [7:0]          a_q,     a_d;
  logic [7:0]          b_q,     b_d;
  logic [15:0]         acc_q,   acc_d;
  logic [15:0]         product_q, product_d;
  logic                out_valid_q, out_valid_d;

  logic [3:0]          a_nib;
  logic [3:0]          b_nib;
  logic [7:0]          pp;
  logic [15:0]         pp_sh;
  logic [15:0]         acc_sum;
  logic                in_ready;
  logic                accept;
  logic                zero_pair;
  logic                last_step;

  // Per-step operand nibble selection.
  assign a_nib = A_HI_SEL[step_q] ? a_q[7:4] : a_q[3:0];
  assign b_nib = B_HI_SEL[step_q] ? b_q[7:4] : b_q[3:0];

  vedic_mul4x4 u_mul4x4 (
    .a_i (a_nib),
    .b_i (b_nib),
    .p_o (pp)
  );

  // Max total is 0xFF*0xFF = 0xFE01, so the 16-bit add cannot overflow.
  assign pp_sh   = {8'h00, pp} << SHIFT_TBL[step_q];
  assign acc_sum = acc_q + pp_sh;

  // DONE can take a new pair in the same cycle its product is consumed.
  assign in_ready  = rst_n && ((state_q == IDLE) ||
                               ((state_q == DONE) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;
  assign zero_pair = SKIP_ZERO && ((bus.a == 8'h00) || (bus.b == 8'h00));
  assign last_step = (step_q == STEP_W'(NSTEPS - 1));

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        // Accept handled below.
      end
      CALC: begin
        acc_d  = acc_sum;
        step_d = step_q + STEP_W'(1);
        if (last_step) begin
          state_d     = DONE;
          step_d      = '0;
          out_valid_d = 1'b1;
          product_d   = acc_sum;
        end
      end
      DONE: begin
        if (bus.out_ready && !bus.in_valid) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    // Operand capture: only possible from IDLE or a consumed DONE.
    if (accept) begin
      a_d    = bus.a;
      b_d    = bus.b;
      acc_d  = '0;
      step_d = '0;
      if (zero_pair) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        product_d   = '0;
      end else begin
        state_d     = CALC;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.product   = product_q;

endmodule
`default_nettype wire
